// File: rtl/rggen_rtl_pkg.sv
// Shared rggen native-bus encodings plus the arbiter state type.
package rggen_rtl_pkg;

  localparam int unsigned RGGEN_ACCESS_WIDTH = 2;
  localparam int unsigned RGGEN_STATUS_WIDTH = 2;

  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_READ         = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rggen_arbiter_state;

endpackage

// File: rtl/rggen_round_robin_select.sv
// Combinational round-robin pick: rotate the doubled request vector by the
// pointer, take the lowest set bit, then rotate the one-hot result back.
module rggen_round_robin_select #(
  parameter int unsigned REQUESTERS    = 2,
  parameter int unsigned POINTER_WIDTH = 1
)(
  input  logic [REQUESTERS-1:0]    request_i,
  input  logic [POINTER_WIDTH-1:0] pointer_i,
  output logic [REQUESTERS-1:0]    grant_o
);

  localparam int unsigned N  = REQUESTERS;
  localparam int unsigned DW = 2 * N;
  localparam int unsigned SW = $clog2(DW) + 1;

  logic [DW-1:0] req_dbl;
  logic [DW-1:0] gnt_dbl;
  logic [N-1:0]  rotated;
  logic [SW-1:0] offset;
  logic          found;

  always_comb begin
    req_dbl = {request_i, request_i};
    rotated = N'(req_dbl >> pointer_i);
    offset  = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rotated[i]) begin
        offset = SW'(i);
        found  = 1'b1;
      end
    end
    gnt_dbl = found ? (DW'(1) << (SW'(pointer_i) + offset)) : '0;
    grant_o = gnt_dbl[N-1:0] | gnt_dbl[DW-1:N];
  end

endmodule

// File: rtl/rggen_native_bus_arbiter.sv
// Round-robin arbiter sharing one rggen native bus between REQUESTERS masters.
// Optional watchdog: define RGGEN_NATIVE_BUS_ARBITER_TIMEOUT_EN.
module rggen_native_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned REQUESTERS     = 2,
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned STROBE_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
)(
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic [REQUESTERS-1:0]                    i_valid,
  input  logic [REQUESTERS*RGGEN_ACCESS_WIDTH-1:0] i_access,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]      i_address,
  input  logic [REQUESTERS*BUS_WIDTH-1:0]          i_write_data,
  input  logic [REQUESTERS*STROBE_WIDTH-1:0]       i_strobe,
  output logic [REQUESTERS-1:0]                    o_ready,
  output logic [RGGEN_STATUS_WIDTH-1:0]            o_status,
  output logic [BUS_WIDTH-1:0]                     o_read_data,
  output logic                                     o_valid,
  output logic [RGGEN_ACCESS_WIDTH-1:0]            o_access,
  output logic [ADDRESS_WIDTH-1:0]                 o_address,
  output logic [BUS_WIDTH-1:0]                     o_write_data,
  output logic [STROBE_WIDTH-1:0]                  o_strobe,
  input  logic                                     i_ready,
  input  logic [RGGEN_STATUS_WIDTH-1:0]            i_status,
  input  logic [BUS_WIDTH-1:0]                     i_read_data
);

  localparam int unsigned N  = REQUESTERS;
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = RGGEN_ACCESS_WIDTH;

  rggen_arbiter_state state_q, state_d;
  logic [N-1:0]  grant_q, grant_d, select_grant;
  logic [PW-1:0] ptr_q, ptr_d, grant_idx, ptr_next;
  logic          done_c;
  logic          timeout_c;

  rggen_round_robin_select #(
    .REQUESTERS    (N),
    .POINTER_WIDTH (PW)
  ) u_select (
    .request_i (i_valid),
    .pointer_i (ptr_q),
    .grant_o   (select_grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int r = 0; r < N; r++) begin
      if (grant_q[r]) grant_idx = PW'(r);
    end
  end

  assign ptr_next = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);

`ifdef RGGEN_NATIVE_BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 32) ? 32 : TW_RAW);

  logic [TW-1:0] count_q, count_d;

  // Counts BUSY cycles; held at zero in IDLE so every grant starts fresh.
  assign count_d   = (state_q == BUSY) ? count_q + TW'(1) : '0;
  assign timeout_c = (state_q == BUSY) && (count_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) count_q <= '0;
    else          count_q <= count_d;
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
  assign timeout_c             = 1'b0;
`endif

  assign done_c = (state_q == BUSY) && (i_ready || timeout_c);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|i_valid) begin
          state_d = BUSY;
          grant_d = select_grant;
        end
      end
      BUSY: begin
        if (done_c) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream fields are an AND-OR mux on the one-hot grant, so IDLE drives zeros.
  always_comb begin
    o_valid      = (state_q == BUSY);
    o_ready      = done_c ? grant_q : '0;
    o_status     = '0;
    o_read_data  = '0;
    o_access     = '0;
    o_address    = '0;
    o_write_data = '0;
    o_strobe     = '0;
    if (done_c) begin
      if (i_ready) begin
        o_status    = i_status;
        o_read_data = i_read_data;
      end else begin
        o_status    = RGGEN_SLAVE_ERROR;
      end
    end
    for (int r = 0; r < N; r++) begin
      if (grant_q[r]) begin
        o_access     = o_access     | i_access[r*CW +: CW];
        o_address    = o_address    | i_address[r*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        o_write_data = o_write_data | i_write_data[r*BUS_WIDTH +: BUS_WIDTH];
        o_strobe     = o_strobe     | i_strobe[r*STROBE_WIDTH +: STROBE_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_rggen_native_bus_arbiter.sv
// Directed bench for rggen_native_bus_arbiter with two requesters; the watchdog
// scenario runs only when RGGEN_NATIVE_BUS_ARBITER_TIMEOUT_EN is defined.
module tb_rggen_native_bus_arbiter;
  import rggen_rtl_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned BW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 4;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [N-1:0]    i_valid = '0;
  logic [N*2-1:0]  i_access = '0;
  logic [N*AW-1:0] i_address = '0;
  logic [N*BW-1:0] i_write_data = '0;
  logic [N*SW-1:0] i_strobe = '0;
  logic [N-1:0]    o_ready;
  logic [1:0]      o_status;
  logic [BW-1:0]   o_read_data;
  logic            o_valid;
  logic [1:0]      o_access;
  logic [AW-1:0]   o_address;
  logic [BW-1:0]   o_write_data;
  logic [SW-1:0]   o_strobe;
  logic            i_ready = 1'b0;
  logic [1:0]      i_status = '0;
  logic [BW-1:0]   i_read_data = '0;

  int total = 0;
  int bad   = 0;

  rggen_native_bus_arbiter #(
    .REQUESTERS     (N),
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .STROBE_WIDTH   (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_access     (i_access),
    .i_address    (i_address),
    .i_write_data (i_write_data),
    .i_strobe     (i_strobe),
    .o_ready      (o_ready),
    .o_status     (o_status),
    .o_read_data  (o_read_data),
    .o_valid      (o_valid),
    .o_access     (o_access),
    .o_address    (o_address),
    .o_write_data (o_write_data),
    .o_strobe     (o_strobe),
    .i_ready      (i_ready),
    .i_status     (i_status),
    .i_read_data  (i_read_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst_n      = 1'b0;
    i_valid      = '0;
    i_ready      = 1'b0;
    i_status     = '0;
    i_read_data  = '0;
    i_access     = {RGGEN_READ, RGGEN_READ};
    i_address    = {8'h41, 8'h40};
    i_write_data = '0;
    i_strobe     = '0;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n     = 1'b0;
    i_valid     = 2'b11;
    i_ready     = 1'b1;
    i_status    = RGGEN_SLAVE_ERROR;
    i_read_data = 32'hDEAD_BEEF;
    step();
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    total++; if (o_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", o_ready); end
    total++; if (o_status !== 2'b00) begin bad++; $display("FAIL reset_status: got %b want 00", o_status); end
    total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", o_read_data); end
    total++; if (o_address !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h want 00", o_address); end
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    i_valid     = 2'b01;
    i_access    = {RGGEN_WRITE, RGGEN_READ};
    i_address   = {8'h99, 8'h10};
    i_read_data = 32'h1234_5678;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rd_c0_valid: got %b want 0", o_valid); end
    step();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rd_c1_valid: got %b want 1", o_valid); end
    total++; if (o_address !== 8'h10) begin bad++; $display("FAIL rd_c1_addr: got %h want 10", o_address); end
    total++; if (o_access !== 2'b10) begin bad++; $display("FAIL rd_c1_access: got %b want 10", o_access); end
    total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL rd_c1_rdata: got %h want 0", o_read_data); end
    step();
    total++; if (o_ready !== 2'b00) begin bad++; $display("FAIL rd_c2_ready: got %b want 00", o_ready); end
    step();
    i_ready     = 1'b1;
    i_status    = RGGEN_OKAY;
    i_read_data = 32'hCAFE_0001;
    #1;
    total++; if (o_ready !== 2'b01) begin bad++; $display("FAIL rd_c3_ready: got %b want 01", o_ready); end
    total++; if (o_read_data !== 32'hCAFE_0001) begin bad++; $display("FAIL rd_c3_rdata: got %h want cafe0001", o_read_data); end
    total++; if (o_status !== 2'b00) begin bad++; $display("FAIL rd_c3_status: got %b want 00", o_status); end
    step();
    i_ready = 1'b0;
    i_valid = 2'b00;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rd_c4_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [7:0]  exp_addr;
    apply_reset();
    i_valid   = 2'b11;
    i_address = {8'h41, 8'h40};
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 8'h40 : 8'h41;
      while (o_valid !== 1'b1 && w < 10) begin
        step();
        w++;
      end
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rr_wait_%0d: got o_valid %b want 1 within 10 cycles", k, o_valid); end
      total++; if (o_address !== exp_addr) begin bad++; $display("FAIL rr_addr_%0d: got %h want %h", k, o_address, exp_addr); end
      i_ready  = 1'b1;
      i_status = RGGEN_OKAY;
      #1;
      total++; if (o_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready_%0d: got %b want %b", k, o_ready, exp_rdy); end
      step();
      i_ready = 1'b0;
      #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rr_gap_%0d: got o_valid %b want 0", k, o_valid); end
    end
    i_valid = 2'b00;
  endtask

  task automatic test_write_req1();
    apply_reset();
    i_valid      = 2'b10;
    i_access     = {RGGEN_WRITE, RGGEN_READ};
    i_address    = {8'h20, 8'h77};
    i_write_data = {32'hA5A5_A5A5, 32'h1111_1111};
    i_strobe     = {4'hF, 4'h3};
    step();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL wr_valid: got %b want 1", o_valid); end
    total++; if (o_access !== 2'b11) begin bad++; $display("FAIL wr_access: got %b want 11", o_access); end
    total++; if (o_address !== 8'h20) begin bad++; $display("FAIL wr_addr: got %h want 20", o_address); end
    total++; if (o_write_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wr_wdata: got %h want a5a5a5a5", o_write_data); end
    total++; if (o_strobe !== 4'hF) begin bad++; $display("FAIL wr_strobe: got %h want f", o_strobe); end
    i_ready  = 1'b1;
    i_status = RGGEN_OKAY;
    #1;
    total++; if (o_ready !== 2'b10) begin bad++; $display("FAIL wr_ready: got %b want 10", o_ready); end
    step();
    i_ready = 1'b0;
    i_valid = 2'b00;
  endtask

  task automatic test_slverr_and_idle_ready();
    apply_reset();
    i_valid = 2'b11;
    step();
    i_ready     = 1'b1;
    i_status    = RGGEN_SLAVE_ERROR;
    i_read_data = 32'h0BAD_0BAD;
    #1;
    total++; if (o_ready !== 2'b01) begin bad++; $display("FAIL err_ready: got %b want 01", o_ready); end
    total++; if (o_status !== 2'b10) begin bad++; $display("FAIL err_status: got %b want 10", o_status); end
    step();
    i_valid  = 2'b10;
    i_status = RGGEN_OKAY;
    #1;
    // IDLE cycle with i_ready still high: nothing may be reported
    total++; if (o_ready !== 2'b00) begin bad++; $display("FAIL idle_ready: got %b want 00", o_ready); end
    total++; if (o_status !== 2'b00) begin bad++; $display("FAIL idle_status: got %b want 00", o_status); end
    total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL idle_rdata: got %h want 0", o_read_data); end
    step();
    total++; if (o_ready !== 2'b10) begin bad++; $display("FAIL next_ready: got %b want 10", o_ready); end
    step();
    i_ready = 1'b0;
    i_valid = 2'b00;
  endtask

  task automatic test_drop_valid();
    apply_reset();
    i_valid = 2'b01;
    step();
    i_valid = 2'b00;
    step();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL drop_valid: got %b want 1", o_valid); end
    i_ready = 1'b1;
    #1;
    total++; if (o_ready !== 2'b01) begin bad++; $display("FAIL drop_ready: got %b want 01", o_ready); end
    step();
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_valid = 2'b11;
    step();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    step();
    total++; if (o_address !== 8'h41) begin bad++; $display("FAIL rst_pre_addr: got %h want 41", o_address); end
    i_ready = 1'b1;
    i_rst_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", o_valid); end
    total++; if (o_ready !== 2'b00) begin bad++; $display("FAIL rst_mid_ready: got %b want 00", o_ready); end
    i_ready = 1'b0;
    #2;
    i_rst_n = 1'b1;
    step();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rst_post_valid: got %b want 1", o_valid); end
    total++; if (o_address !== 8'h40) begin bad++; $display("FAIL rst_post_addr: got %h want 40", o_address); end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    i_valid = 2'b00;
  endtask

`ifdef RGGEN_NATIVE_BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    i_valid     = 2'b11;
    i_read_data = 32'hFFFF_FFFF;
    i_status    = RGGEN_OKAY;
    step();
    for (int c = 1; c < 4; c++) begin
      total++; if (o_ready !== 2'b00) begin bad++; $display("FAIL to_wait_%0d: got %b want 00", c, o_ready); end
      step();
    end
    total++; if (o_ready !== 2'b01) begin bad++; $display("FAIL to_ready: got %b want 01", o_ready); end
    total++; if (o_status !== 2'b10) begin bad++; $display("FAIL to_status: got %b want 10", o_status); end
    total++; if (o_read_data !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 0", o_read_data); end
    step();
    i_valid = 2'b10;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL to_idle: got %b want 0", o_valid); end
    step();
    total++; if (o_address !== 8'h41) begin bad++; $display("FAIL to_next_addr: got %h want 41", o_address); end
    i_valid = 2'b00;
    apply_reset();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_req1();
    test_slverr_and_idle_ready();
    test_drop_valid();
    test_reset_mid();
`ifdef RGGEN_NATIVE_BUS_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
